// File: rtl/dcache_responder_pkg.sv
// dcache_responder_pkg: shared word/frame types and the cache FSM encoding for dcache_responder
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef struct packed {
    logic        valid;
    logic        dirty;
    logic [28:0] tag;
    word_t [1:0] data;
  } dcache_frame_t;
endpackage

package dcache_responder_pkg;
  localparam int DSETS = 16;
  localparam int DIDX_W = $clog2(DSETS);
  localparam int DTAG_W = 29 - DIDX_W;
  typedef enum logic [3:0] {IDLE, WB0, WB1, LD0, LD1, FLUSH, FWB0, FWB1, DONE} dcache_state_t;
endpackage

// File: rtl/dcache_responder_frames.sv
// dcache_responder_frames: frame array (clk, rst, async read port ridx->rframe, write port wen/widx/wframe; rst clears valid/dirty)
module dcache_responder_frames
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16,
  parameter int IW = $clog2(SETS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] ridx,
  output dcache_frame_t rframe,
  input  logic          wen,
  input  logic [IW-1:0] widx,
  input  dcache_frame_t wframe
);
  dcache_frame_t frames [SETS];
  assign rframe = frames[ridx];
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < SETS; i++) begin
        frames[i].valid <= 1'b0;
        frames[i].dirty <= 1'b0;
      end
    else if (wen)
      frames[widx] <= wframe;
endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-back dcache (CLK/RST; datapath halt,dmemREN/WEN,datomic,dmemaddr,dmemstore -> dhit,dmemload,flushed; memory dREN,dWEN,daddr,dstore <- dwait,dload); LL/SC under DCACHE_LLSC_EN
module dcache_responder
  import cpu_types_pkg::*;
  import dcache_responder_pkg::*;
#(
  parameter int SETS = DSETS
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        datomic,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);
  localparam int IW = $clog2(SETS);
  dcache_state_t state;
  logic [IW-1:0] fcnt, idx;
  logic [28:0] maddr;
  word_t w0;
  dcache_frame_t rframe, wframe;
  logic wen, wr, rd, hit, sc, sc_fail, wr_hit, wb, ld, blk, unused;
  assign unused = ^{datomic, dmemaddr[1:0]};
  assign wr = dmemWEN;
  assign rd = dmemREN && !dmemWEN;
  assign idx = state == IDLE ? dmemaddr[2+IW:3] :
               (state == FLUSH || state == FWB0 || state == FWB1) ? fcnt : maddr[IW-1:0];
  assign hit = rframe.valid && rframe.tag == dmemaddr[31:3];
  assign dhit = state == IDLE && !halt && (dmemREN || dmemWEN) && (hit || sc_fail);
  assign wr_hit = dhit && wr && !sc_fail;
  assign dmemload = !dhit ? '0 : rd ? rframe.data[dmemaddr[2]] : {31'b0, sc && !sc_fail};
  assign wb = state == WB0 || state == WB1 || state == FWB0 || state == FWB1;
  assign ld = state == LD0 || state == LD1;
  assign blk = state == WB1 || state == LD1 || state == FWB1;
  assign dWEN = wb;
  assign dREN = ld;
  assign daddr = wb ? {rframe.tag, blk, 2'b00} : ld ? {maddr, blk, 2'b00} : '0;
  assign dstore = wb ? rframe.data[blk] : '0;
  assign flushed = state == DONE;
`ifdef DCACHE_LLSC_EN
  logic link_v;
  logic [29:0] link_a;
  assign sc = wr && datomic;
  assign sc_fail = sc && !(link_v && link_a == dmemaddr[31:2]);
  always_ff @(posedge CLK)
    if (RST) begin
      link_v <= 1'b0;
      link_a <= '0;
    end else if (dhit && rd && datomic) begin
      link_v <= 1'b1;
      link_a <= dmemaddr[31:2];
    end else if (wr_hit && link_a == dmemaddr[31:2])
      link_v <= 1'b0;
`else
  assign sc = 1'b0;
  assign sc_fail = 1'b0;
`endif
  always_comb begin
    wframe = rframe;
    wen = 1'b0;
    if (wr_hit) begin
      wen = 1'b1;
      wframe.dirty = 1'b1;
      wframe.data[dmemaddr[2]] = dmemstore;
    end else if (state == LD1 && !dwait) begin
      wen = 1'b1;
      wframe = {1'b1, 1'b0, maddr, dload, w0};
    end else if (state == FWB1 && !dwait) begin
      wen = 1'b1;
      wframe.dirty = 1'b0;
    end
  end
  dcache_responder_frames #(.SETS(SETS)) u_frames (
    .clk(CLK), .rst(RST), .ridx(idx), .rframe(rframe), .wen(wen), .widx(idx), .wframe(wframe)
  );
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      fcnt <= '0;
      maddr <= '0;
      w0 <= '0;
    end else
      case (state)
        IDLE:
          if (halt)
            state <= FLUSH;
          else if ((dmemREN || dmemWEN) && !hit && !sc_fail) begin
            maddr <= dmemaddr[31:3];
            state <= rframe.valid && rframe.dirty ? WB0 : LD0;
          end
        WB0: if (!dwait) state <= WB1;
        WB1: if (!dwait) state <= LD0;
        LD0:
          if (!dwait) begin
            w0 <= dload;
            state <= LD1;
          end
        LD1: if (!dwait) state <= IDLE;
        FLUSH:
          if (rframe.valid && rframe.dirty)
            state <= FWB0;
          else if (fcnt == IW'(SETS - 1))
            state <= DONE;
          else
            fcnt <= fcnt + 1'b1;
        FWB0: if (!dwait) state <= FWB1;
        FWB1: if (!dwait) state <= FLUSH;
        default: state <= DONE;
      endcase
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: scoreboard bench for dcache_responder with a flat word-addressed memory model
module tb_dcache_responder;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mop_t;
  logic clk = 1'b0, rst = 1'b1, halt = 1'b0, dmemREN = 1'b0, dmemWEN = 1'b0, datomic = 1'b0, dwait = 1'b0;
  logic [31:0] dmemaddr = '0, dmemstore = '0;
  logic dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore, dload;
  logic [31:0] mem [256];
  mop_t exp_mem [$];
  logic [31:0] exp_hit [$];
  int n_chk = 0, n_fail = 0;
  dcache_responder dut (
    .CLK(clk), .RST(rst), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload)
  );
  always #5 clk = ~clk;
  assign dload = mem[daddr[9:2]];
  always @(posedge clk) if (dWEN && !dwait) mem[daddr[9:2]] <= dstore;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (dhit) begin
      if (exp_hit.size() == 0) check("dhit_extra", 32'(exp_hit.size()), 1);
      else check("dmemload", dmemload, exp_hit.pop_front());
    end
    if ((dREN || dWEN) && !dwait) begin
      if (exp_mem.size() == 0) check("mem_extra", 32'(exp_mem.size()), 1);
      else begin
        mop_t m;
        m = exp_mem.pop_front();
        check("mem_we", {31'b0, dWEN}, {31'b0, m.we});
        check("mem_ren", {31'b0, dREN}, {31'b0, !m.we});
        check("mem_addr", daddr, m.addr);
        if (m.we) check("mem_data", dstore, m.data);
      end
    end
  end
  task automatic mop(input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_mem.push_back('{we, a, d});
  endtask
  task automatic access(input logic w, input logic at, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    exp_hit.push_back(exp);
    dmemREN = !w; dmemWEN = w; datomic = at; dmemaddr = a; dmemstore = d;
    lat = 0;
    @(negedge clk);
    while (!dhit && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("dhit_seen", {31'b0, dhit}, 1);
    check("latency", 32'(lat), 32'(exp_lat));
    @(posedge clk);
    #1 dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
  endtask
  task automatic outs_zero(input string tag);
    check({tag, "_dhit"}, {31'b0, dhit}, 0);
    check({tag, "_dmemload"}, dmemload, 0);
    check({tag, "_flushed"}, {31'b0, flushed}, 0);
    check({tag, "_dREN"}, {31'b0, dREN}, 0);
    check({tag, "_dWEN"}, {31'b0, dWEN}, 0);
    check({tag, "_daddr"}, daddr, 0);
    check({tag, "_dstore"}, dstore, 0);
  endtask
  initial begin
    int n;
    logic [31:0] sc_word;
    for (int i = 0; i < 256; i++) mem[i] = 32'h5000_0000 | i;
    mem[8'h40] = 32'hAAAA0001; mem[8'h41] = 32'hAAAA0002;
    mem[8'h60] = 32'hBBBB0001; mem[8'h61] = 32'hBBBB0002;
    mem[8'h80] = 32'hCCCC0001; mem[8'h81] = 32'hCCCC0002;
    repeat (2) @(posedge clk);
    #1 outs_zero("reset");
    rst = 1'b0;
    mop(0, 32'h100, 0); mop(0, 32'h104, 0);
    access(0, 0, 32'h100, 0, 32'hAAAA0001, 3);
    access(0, 0, 32'h104, 0, 32'hAAAA0002, 0);
    access(1, 0, 32'h100, 32'hDEAD, 0, 0);
    mop(1, 32'h100, 32'hDEAD); mop(1, 32'h104, 32'hAAAA0002); mop(0, 32'h180, 0); mop(0, 32'h184, 0);
    access(0, 0, 32'h180, 0, 32'hBBBB0001, 5);
    mop(0, 32'h100, 0); mop(0, 32'h104, 0);
    exp_hit.push_back(32'hDEAD);
    dwait = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h100;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_daddr", daddr, 32'h100);
      check("stall_dren", {31'b0, dREN}, 1);
      check("stall_nohit", {31'b0, dhit}, 0);
    end
    @(posedge clk);
    #1 dwait = 1'b0;
    @(negedge clk) check("stall_ld0_nohit", {31'b0, dhit}, 0);
    @(negedge clk) check("stall_ld1_nohit", {31'b0, dhit}, 0);
    @(negedge clk) check("stall_dhit", {31'b0, dhit}, 1);
    @(posedge clk);
    #1 dmemREN = 1'b0;
    mop(0, 32'h200, 0); mop(0, 32'h204, 0);
    access(0, 1, 32'h200, 0, 32'hCCCC0001, 3);
    access(1, 1, 32'h200, 32'd7, 32'd0
`ifdef DCACHE_LLSC_EN
      | 32'd1
`endif
      , 0);
    access(0, 0, 32'h200, 0, 32'd7, 0);
    access(1, 1, 32'h200, 32'd9, 32'd0, 0);
`ifdef DCACHE_LLSC_EN
    sc_word = 32'd7;
`else
    sc_word = 32'd9;
`endif
    access(0, 0, 32'h200, 0, sc_word, 0);
    mop(1, 32'h200, sc_word); mop(1, 32'h204, 32'hCCCC0002); mop(0, 32'h300, 0); mop(0, 32'h304, 0);
    access(0, 0, 32'h300, 0, 32'h500000C0, 5);
    mop(0, 32'h010, 0); mop(0, 32'h014, 0);
    access(1, 0, 32'h010, 32'h1111, 0, 3);
    mop(0, 32'h048, 0); mop(0, 32'h04C, 0);
    access(1, 0, 32'h04C, 32'h2222, 0, 3);
    mop(1, 32'h010, 32'h1111); mop(1, 32'h014, 32'h50000005);
    mop(1, 32'h048, 32'h50000012); mop(1, 32'h04C, 32'h2222);
    halt = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!flushed && n < 300);
    check("flushed", {31'b0, flushed}, 1);
    check("flush_len_ok", {31'b0, n >= 20}, 1);
    check("flush_words_left", 32'(exp_mem.size()), 0);
    @(posedge clk);
    #1 halt = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("done_flushed", {31'b0, flushed}, 1);
      check("done_nohit", {31'b0, dhit}, 0);
    end
    @(posedge clk);
    #1 rst = 1'b1; dmemREN = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    mop(0, 32'h180, 0); mop(0, 32'h184, 0);
    dmemREN = 1'b1; dmemaddr = 32'h180;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dREN && daddr == 32'h184) && n < 10);
    check("midfill_ld1", daddr, 32'h184);
    rst = 1'b1; dmemREN = 1'b0;
    @(posedge clk);
    #1 outs_zero("midfill");
    rst = 1'b0;
    mop(0, 32'h180, 0); mop(0, 32'h184, 0);
    access(0, 0, 32'h180, 0, 32'hBBBB0001, 3);
    repeat (2) @(posedge clk);
    check("hits_left", 32'(exp_hit.size()), 0);
    check("mem_left", 32'(exp_mem.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_responder.md
# dcache_responder

Direct-mapped, write-back data cache that serves the `dcache` side of the datapath–cache interface. It answers datapath loads and stores with `dhit` and `dmemload`, and supports LL/SC through `datomic`. On `halt` it writes back every dirty line and then raises `flushed`. It sits between the datapath and the memory arbiter, and drives the arbiter's data-side request port.

## Interface
- `SETS`, default 16: number of frames; must be a power of two.
- `BLKWORDS`, fixed at 2: words per block; not a free parameter.
- `CLK` input, 1 bit: system clock; all state updates on its rising edge.
- `RST` input, 1 bit: synchronous, active-high reset.
- `halt` input, 1 bit: datapath stop; starts the flush.
- `dmemREN`, `dmemWEN`, `datomic` input, 1 bit each: datapath read, write and atomic qualifier.
- `dmemaddr`, `dmemstore` input, 32 bits: byte address and store data.
- `dhit` output, 1 bit: request completed this cycle.
- `dmemload` output, 32 bits: load data, or the SC result (1 = success, 0 = fail).
- `flushed` output, 1 bit: flush complete.
- `dREN`, `dWEN` output, 1 bit each: memory read and write request.
- `daddr`, `dstore` output, 32 bits: memory word address and write data.
- `dwait` input, 1 bit: memory busy; the current memory word is done on the first cycle it is low.
- `dload` input, 32 bits: memory read data, valid when `dwait` is low.

## Operation
- **Address split:** `[1:0]` byte offset (ignored), `[2]` block offset, `[2+log2(SETS):3]` index, remaining upper bits tag.
- **Frame contents:** valid, dirty, tag, two data words.
- **FSM states:** IDLE, WB0, WB1, LD0, LD1, FLUSH, FWB0, FWB1, DONE.
- **IDLE:**
  - A request is `dmemREN` or `dmemWEN`. If both are high, the write wins.
  - **Hit** (valid and tag match): `dhit` is high combinationally.
    - Read: `dmemload` = selected word.
    - Write: the word is updated and dirty set at the clock edge.
  - **Miss:** go to WB0 if the frame is valid and dirty, otherwise to LD0.
- **WB0/WB1:** `dWEN` high; `daddr` = {old tag, index, 0/1, 2'b00}; `dstore` = old word 0/1. Each state advances when `dwait` is low.
- **LD0/LD1:**
  - `dREN` high; `daddr` = {new tag, index, 0/1, 2'b00}; `dload` is captured on `!dwait`.
  - Leaving LD1 sets the frame valid, clears dirty, writes the tag, and returns to IDLE.
  - The request then hits on the next cycle.
- **Halt:** `halt` is sampled only in IDLE and has priority over any request that cycle; the next state is FLUSH.
  - A miss already in progress completes its fill first, without asserting `dhit`.
- **FLUSH:** a frame counter scans indices 0..SETS-1.
  - Dirty and valid frame: go to FWB0 → FWB1 (same signalling as WB0/WB1), clear dirty, then return to FLUSH.
  - Clean frame: skip it in one cycle.
  - After index SETS-1, go to DONE.
- **DONE:**
  - `flushed` = 1 and `dhit` = 0; all requests are ignored.
  - The block stays in DONE until `RST`.
- **LL/SC** (with `DCACHE_LLSC_EN`):
  - **LL** (`dmemREN` & `datomic`): behaves as a normal load; on its `dhit` cycle, link ← {1, `dmemaddr[31:2]`}.
  - **SC** (`dmemWEN` & `datomic`), link valid and address match: performs the write as normal and returns `dmemload` = 1 on `dhit`; link is cleared.
  - **SC fail:** no write, no miss handling; `dhit` = 1 in IDLE the same cycle, `dmemload` = 0.
  - Any completed write to the linked word clears the link.

## Timing
- **Reset:** all frames invalid and clean; link invalid; frame counter 0; state IDLE.
  - All outputs 0: `dhit`, `dmemload`, `flushed`, `dREN`, `dWEN`, `daddr`, `dstore`.
- **Reset mid-operation:** a memory transfer is abandoned and the state returns to IDLE on the next edge.
- **Latency:**
  - Hit: 0 cycles, `dhit` in the request cycle.
  - Clean miss: 2 memory words plus 1 IDLE cycle.
  - Dirty miss: 4 memory words plus 1 cycle.
- **Memory requests:** `dREN`/`dWEN` are never high together. `daddr`/`dstore` stay stable while `dwait` is high.
- **`dhit` duration:** high for exactly one cycle per completed request. The datapath deasserts or changes its request after `dhit`.
- **Flush duration:** ≥ SETS cycles plus 2 memory words per dirty frame. `flushed` rises on the cycle DONE is entered.

## Configuration
- **`DCACHE_LLSC_EN` defined:** link register and SC success/fail logic are compiled in, as described above.
- **Undefined:**
  - `datomic` is ignored.
  - LL behaves as a normal load.
  - SC behaves as a normal store, with `dmemload` = loaded word semantics not applicable (driven 0).

## Structure
- **`cpu_types_pkg`:** `word_t`, and a `dcache_frame_t` struct {valid, dirty, tag, data[2]}.
- **Cache package:** a `dcache_state_t` enum, plus `DTAG_W`, `DIDX_W` derived from `SETS`.
- **Sub-module `dcache_frames`:** the frame array, with one read port, one write port, and synchronous reset clearing the valid/dirty bits. FSM and link register stay in the top module.

## Test plan
- **Cold read miss:** read 0x100 with memory words 0xAAAA0001/0xAAAA0002 → `dREN` issues 0x100 then 0x104; `dhit` 1 cycle later; `dmemload` = 0xAAAA0001.
- **Write hit then conflict:** write 0xDEAD to 0x100, then read 0x180 (same index) → WB of 0x100/0x104 with 0xDEAD/0xAAAA0002, followed by LD of 0x180/0x184.
- **`dwait` stall:** hold `dwait` high for 5 cycles in LD0 → `daddr` stable and no `dhit` until 1 cycle after LD1 completes.
- **LL/SC:**
  - LL 0x200 then SC 0x200 of 7 → `dmemload` = 1 and the word becomes 7.
  - A second SC to 0x200 → `dmemload` = 0 and the word is unchanged.
- **Flush:** dirty frames 2 and 9, then `halt` → exactly 4 `dWEN` words in index order; `flushed` high and held.
- **Reset mid-fill:** assert `RST` during LD1 → all outputs 0 next cycle; a re-read of the same address misses.
